// File: rtl/fetch.sv
// Instruction fetch and stage sequencer for the multi-cycle core.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// latches it into IR and steps FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned branch target
// redirects to TRAP_VECTOR and pulses trap_o). Default build: target is
// force-aligned and trap_o is tied low.
//
// Handshake: imem_req_o is high for every cycle spent in FETCH (outside reset)
// with imem_addr_o held at pc_o; a transfer completes on the first posedge where
// imem_req_o and imem_ack_i are both high. The ack is ignored in every other
// stage and during reset. stage_o exposes the FSM state directly.
module fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        mem_busy_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic [2:0]  stage_o,
  output logic        trap_o
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } stage_e;

  stage_e      r_stage;
  stage_e      w_stage_next;
  logic        w_fetch_done;
  logic        w_wb_exit;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_next_pc;
  logic        w_trap_set;

  // Stage register; reset always restarts in FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage <= FETCH;
    end else begin
      r_stage <= w_stage_next;
    end
  end

  // Next-stage decode plus the two datapath strobes (IR load, PC update).
  always_comb begin
    w_stage_next = FETCH;
    w_fetch_done = 1'b0;
    w_wb_exit    = 1'b0;
    case (r_stage)
      FETCH: begin
        if (imem_ack_i) begin
          w_stage_next = DECODE;
          w_fetch_done = 1'b1;
        end else begin
          w_stage_next = FETCH;
        end
      end
      DECODE:    w_stage_next = EXECUTE;
      EXECUTE:   w_stage_next = MEMORY;
      MEMORY:    w_stage_next = mem_busy_i ? MEMORY : WRITEBACK;
      WRITEBACK: begin
        w_stage_next = FETCH;
        w_wb_exit    = 1'b1;
      end
      // Illegal encodes (5-7) recover to FETCH.
      default:   w_stage_next = FETCH;
    endcase
  end

  // Redirect target selection; misaligned handling depends on the build.
  always_comb begin
    w_redirect_pc = {branch_target_i[31:2], 2'b00};
    w_trap_set    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (branch_target_i[1:0] != 2'b00) begin
      w_redirect_pc = TRAP_VECTOR;
      w_trap_set    = branch_taken_i;
    end
`endif
    w_next_pc = branch_taken_i ? w_redirect_pc : (r_pc + 32'd4);
  end

  // PC updates only at WRITEBACK exit, IR only at FETCH exit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
      r_ir <= NOP_INSN;
    end else begin
      if (w_fetch_done) begin
        r_ir <= imem_data_i;
      end
      if (w_wb_exit) begin
        r_pc <= w_next_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_trap;

  // Trap flag is set on the redirecting edge and cleared on the next one,
  // so it covers exactly the first FETCH cycle of the trap vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_wb_exit & w_trap_set;
    end
  end

  assign trap_o = r_trap;
`else
  logic w_unused_trap;
  assign w_unused_trap = ^{TRAP_VECTOR, w_trap_set};
  assign trap_o        = 1'b0;
`endif

  assign imem_req_o  = (r_stage == FETCH) & reset;
  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign ir_o        = r_ir;
  assign stage_o     = r_stage;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a table of per-instruction vectors (ack
// delay, memory busy cycles, fetched word, branch inputs, expected next PC and
// trap) driven through complete instructions, plus hand-written reset sequences.
// Fetched words/PCs go through an expected queue popped when DECODE is seen.
module tb_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        mem_busy_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic [2:0]  stage_o;
  logic        trap_o;

  fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .mem_busy_i      (mem_busy_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .ir_o            (ir_o),
    .stage_o         (stage_o),
    .trap_o          (trap_o)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          delay;
    int          busy;
    logic [31:0] data;
    logic        bt;
    logic [31:0] tgt;
    logic        bt_exec;
    logic [31:0] exp_next;
    logic        exp_trap;
  } vec_t;

  localparam int NV = 10;
  vec_t        vecs[NV];
  logic [63:0] exp_q[$];
  int          n_chk;
  int          n_err;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_trap;

  // Advance one cycle and sample 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold reset low for n cycles, checking the reset state each cycle,
  // then release it and spend one idle FETCH cycle.
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_pc", pc_o, 32'h0000_0000);
      chk("rst_ir", ir_o, 32'h0000_0013);
      chk("rst_stage", {29'd0, stage_o}, 32'd0);
      chk("rst_trap", {31'd0, trap_o}, 32'd0);
    end
    imem_ack_i = 1'b0;
    reset      = 1'b1;
    step();
    m_pc   = 32'h0000_0000;
    m_ir   = 32'h0000_0013;
    m_trap = 1'b0;
  endtask

  // Run one full instruction starting in the first sampled FETCH cycle.
  task automatic run_insn(input vec_t v);
    logic [63:0] e;
    chk("f_stage", {29'd0, stage_o}, 32'd0);
    chk("f_req", {31'd0, imem_req_o}, 32'd1);
    chk("f_addr", imem_addr_o, m_pc);
    chk("f_trap_first", {31'd0, trap_o}, {31'd0, m_trap});
    m_trap = 1'b0;
    for (int i = 0; i < v.delay; i++) begin
      imem_ack_i  = 1'b0;
      imem_data_i = $urandom;
      step();
      chk("wait_stage", {29'd0, stage_o}, 32'd0);
      chk("wait_req", {31'd0, imem_req_o}, 32'd1);
      chk("wait_addr", imem_addr_o, m_pc);
      chk("wait_ir", ir_o, m_ir);
      chk("wait_trap", {31'd0, trap_o}, 32'd0);
    end
    imem_ack_i  = 1'b1;
    imem_data_i = v.data;
    exp_q.push_back({m_pc, v.data});
    step();
    imem_ack_i = 1'b0;
    chk("d_stage", {29'd0, stage_o}, 32'd1);
    chk("d_req", {31'd0, imem_req_o}, 32'd0);
    chk("d_trap", {31'd0, trap_o}, 32'd0);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      chk("sb_ir", ir_o, e[31:0]);
      chk("sb_pc", pc_o, e[63:32]);
    end
    m_ir = v.data;
    // Stray ack in DECODE must not reload IR.
    imem_ack_i  = 1'b1;
    imem_data_i = ~v.data;
    step();
    imem_ack_i = 1'b0;
    chk("e_stage", {29'd0, stage_o}, 32'd2);
    chk("e_ir", ir_o, m_ir);
    // Branch request in EXECUTE must be ignored.
    branch_taken_i  = v.bt_exec;
    branch_target_i = 32'h0000_0800;
    step();
    branch_taken_i = 1'b0;
    chk("m_stage", {29'd0, stage_o}, 32'd3);
    for (int i = 0; i < v.busy; i++) begin
      mem_busy_i = 1'b1;
      step();
      chk("busy_stage", {29'd0, stage_o}, 32'd3);
    end
    mem_busy_i = 1'b0;
    step();
    chk("w_stage", {29'd0, stage_o}, 32'd4);
    chk("w_pc", pc_o, m_pc);
    chk("w_ir", ir_o, m_ir);
    branch_taken_i  = v.bt;
    branch_target_i = v.tgt;
    step();
    branch_taken_i = 1'b0;
    chk("nx_stage", {29'd0, stage_o}, 32'd0);
    chk("nx_pc", pc_o, v.exp_next);
    m_pc   = v.exp_next;
    m_trap = v.exp_trap;
  endtask

  initial begin
    logic [31:0] stray;
    n_chk           = 0;
    n_err           = 0;
    reset           = 1'b0;
    imem_ack_i      = 1'b0;
    imem_data_i     = 32'd0;
    mem_busy_i      = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;

    //          delay busy data          bt    tgt            bt_exec exp_next      trap
    vecs[0] = '{0, 0, 32'h0020_8133, 1'b0, 32'h0,          1'b0, 32'h0000_0004, 1'b0};
    vecs[1] = '{3, 0, 32'h1111_1111, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b0};
    vecs[2] = '{0, 2, 32'h2222_2222, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b0};
    vecs[3] = '{0, 0, 32'h3333_3333, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0};
    vecs[4] = '{1, 1, 32'h4444_4444, 1'b0, 32'h0,          1'b1, 32'h0000_0044, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[5] = '{0, 0, 32'h5555_5555, 1'b1, 32'h0000_0042, 1'b0, 32'h0000_0100, 1'b1};
`else
    vecs[5] = '{0, 0, 32'h5555_5555, 1'b1, 32'h0000_0042, 1'b0, 32'h0000_0040, 1'b0};
`endif
    vecs[6] = '{2, 0, 32'h6666_6666, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[7] = '{0, 0, 32'h7777_7777, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b0};
    vecs[8] = '{$urandom_range(0, 4), $urandom_range(0, 4), $urandom, 1'b0, 32'h0, 1'b0,
                32'h0000_0004, 1'b0};
    vecs[9] = '{$urandom_range(0, 4), $urandom_range(0, 4), $urandom, 1'b0, 32'h0, 1'b1,
                32'h0000_0008, 1'b0};

    do_reset(3);
    for (int k = 0; k < NV; k++) begin
      run_insn(vecs[k]);
    end

    // Reset while waiting for an ack in FETCH; an ack in the reset cycle is ignored.
    imem_ack_i = 1'b0;
    step();
    step();
    chk("mid_req_before", {31'd0, imem_req_o}, 32'd1);
    stray       = 32'hDEAD_BEEF;
    reset       = 1'b0;
    imem_ack_i  = 1'b1;
    imem_data_i = stray;
    #1;
    chk("mid_req_comb", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("mid_req", {31'd0, imem_req_o}, 32'd0);
    chk("mid_pc", pc_o, 32'h0000_0000);
    chk("mid_ir", ir_o, 32'h0000_0013);
    chk("mid_stage", {29'd0, stage_o}, 32'd0);
    imem_ack_i = 1'b0;
    reset      = 1'b1;
    step();
    m_pc   = 32'h0000_0000;
    m_ir   = 32'h0000_0013;
    m_trap = 1'b0;
    chk("post_rst_ir", ir_o, 32'h0000_0013);
    run_insn('{1, 0, 32'h0AAA_5555, 1'b0, 32'h0, 1'b0, 32'h0000_0004, 1'b0});

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
